imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer side of the instruction memory consumed by the program counter and fetch path.
- Receives a byte stream over a valid/ready handshake with a 2-byte length header, then assembles little-endian 32-bit words.
- Writes each word into the instruction BRAM port and asserts `start` once the full program is loaded, releasing the PC to fetch.

Parameters:
- ADDR_WIDTH, 10, instruction memory word-address width; capacity is 2**ADDR_WIDTH words.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_req  input  1  one-cycle request to begin a new program load.
- rx_data  input  8  incoming stream byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader accepts a byte this cycle; a transfer occurs when rx_valid && rx_ready.
- imem_ena  output  1  BRAM port enable.
- imem_wea  output  1  BRAM write enable.
- imem_addr  output  ADDR_WIDTH  BRAM word address.
- imem_din  output  32  BRAM write data.
- start  output  1  program loaded; PC may run.
- busy  output  1  load in progress.
- error  output  1  last load aborted on a bad length.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; all outputs 0: rx_ready, imem_ena, imem_wea, imem_addr, imem_din, start, busy, error.
  - Internal len, word_cnt and byte_idx are cleared.
- State IDLE: rx_ready=0. On load_req go to LEN_LO; clear error and word_cnt.
- State LEN_LO:
  - rx_ready=1.
  - On transfer: len[7:0]=rx_data, go to LEN_HI.
- State LEN_HI:
  - rx_ready=1.
  - On transfer: len[15:8]=rx_data.
  - If the full 16-bit len is 0 or greater than 2**ADDR_WIDTH, go to ERR.
  - Otherwise clear byte_idx and go to DATA.
- State DATA:
  - rx_ready=1.
  - On transfer: word[8*byte_idx +: 8]=rx_data, so the first byte lands in bits [7:0] (little-endian); byte_idx++.
  - On the 4th byte (byte_idx==3 at transfer), go to WRITE.
- State WRITE (exactly 1 cycle):
  - rx_ready=0.
  - imem_ena=1, imem_wea=1, imem_addr=word_cnt[ADDR_WIDTH-1:0], imem_din=assembled word.
  - word_cnt++.
  - If the incremented word_cnt==len, go to DONE; otherwise clear byte_idx and go to DATA.
- State DONE:
  - start=1, held until the next load_req; rx_ready=0.
  - On load_req: start=0 from the next cycle, go to LEN_LO.
- State ERR:
  - error=1, start=0, rx_ready=0; held until load_req.
  - On load_req: clear error, go to LEN_LO.
- Output timing:
  - imem_ena and imem_wea are high only in WRITE.
  - imem_addr and imem_din hold their last values outside WRITE.
  - Outputs are decoded from the registered state; no combinational path from rx_valid to the BRAM outputs.
- rx_ready path: rx_ready depends only on state, never on rx_valid.
- busy=1 in LEN_LO, LEN_HI, DATA and WRITE.
- load_req while busy is ignored.
- Bytes presented while rx_ready=0 are not consumed, and the source must hold them.
- Throughput: at most 1 word per 5 cycles (4 accept cycles + 1 WRITE cycle). Stalls on rx_valid=0 extend DATA indefinitely with no timeout.
- Address range: word_cnt is wide enough for len=2**ADDR_WIDTH, so the last write lands at address 2**ADDR_WIDTH-1 and addresses never wrap.
- Reset mid-load:
  - All outputs drop immediately and no further writes occur.
  - Words already written stay in memory; start remains 0 until a complete load finishes.

Test Plan:
- Normal load:
  - Stimulus: reset, then load_req, then bytes 02 00 78 56 34 12 EF BE AD DE, with rx_valid always high.
  - Response: exactly two single-cycle writes, addr0=0x12345678 and addr1=0xDEADBEEF.
  - After that, start=1, busy=0, error=0.
- Zero length:
  - Stimulus: header 00 00.
  - Response: error=1, start=0, no imem_wea pulse.
  - Then load_req with header 01 00 and 13 00 00 00: addr0=0x00000013, error=0, start=1.
- Oversize length:
  - Stimulus: ADDR_WIDTH=10, header 01 04 (len 1025).
  - Response: error=1, no writes. Header 00 04 (len 1024) is accepted; its last write is at addr 1023, followed by start=1.
- Stalls:
  - Stimulus: rx_valid toggled every other cycle plus random gaps during the scenario 1 stream.
  - Response: memory contents identical to scenario 1; rx_ready=0 in every WRITE cycle.
- Reset mid-load:
  - Stimulus: async reset asserted after 2 data bytes.
  - Response: outputs 0 before the next clock edge, no write, start=0.
  - After reset release, a fresh load succeeds.
- load_req during busy:
  - Stimulus: assert load_req while in DATA.
  - Response: ignored, and the load completes normally.
  - A load_req while in DONE drops start on the next cycle and re-enters LEN_LO.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-BRAM write port used by imem_loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  imem_ena;
  logic                  imem_wea;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_din;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_ena, imem_wea, imem_addr, imem_din
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_ena, imem_wea, imem_addr, imem_din
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: 2-byte little-endian length header, then
// little-endian 32-bit words written to the BRAM port; raises start when done.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_req,
  imem_loader_if.slave bus,
  output logic         start,
  output logic         busy,
  output logic         error
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  state_t                state;
  logic [15:0]           len;
  logic [ADDR_WIDTH:0]   word_cnt;
  logic [ADDR_WIDTH:0]   cnt_next;
  logic [1:0]            byte_idx;
  logic [23:0]           word;
  logic [15:0]           len_full;
  logic                  transfer;

  always_comb begin
    transfer = bus.rx_valid && bus.rx_ready;
    len_full = {bus.rx_data, len[7:0]};
    cnt_next = word_cnt + (ADDR_WIDTH+1)'(1);
  end

  // Outputs are registered alongside the state so each one reflects the
  // state being entered, keeping rx_valid off any output's combinational path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      len           <= '0;
      word_cnt      <= '0;
      byte_idx      <= '0;
      word          <= '0;
      bus.rx_ready  <= 1'b0;
      bus.imem_ena  <= 1'b0;
      bus.imem_wea  <= 1'b0;
      bus.imem_addr <= '0;
      bus.imem_din  <= '0;
      start         <= 1'b0;
      busy          <= 1'b0;
      error         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (load_req) begin
            state        <= LEN_LO;
            word_cnt     <= '0;
            bus.rx_ready <= 1'b1;
            busy         <= 1'b1;
            start        <= 1'b0;
            error        <= 1'b0;
          end
        end

        LEN_LO: begin
          if (transfer) begin
            len[7:0] <= bus.rx_data;
            state    <= LEN_HI;
          end
        end

        LEN_HI: begin
          if (transfer) begin
            len[15:8] <= bus.rx_data;
            if (len_full == 16'd0 || {1'b0, len_full} > CAPACITY) begin
              state        <= ERR;
              bus.rx_ready <= 1'b0;
              busy         <= 1'b0;
              error        <= 1'b1;
            end else begin
              byte_idx <= '0;
              state    <= DATA;
            end
          end
        end

        DATA: begin
          if (transfer) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state         <= WRITE;
              bus.rx_ready  <= 1'b0;
              bus.imem_ena  <= 1'b1;
              bus.imem_wea  <= 1'b1;
              bus.imem_addr <= word_cnt[ADDR_WIDTH-1:0];
              bus.imem_din  <= {bus.rx_data, word};
            end else begin
              case (byte_idx)
                2'd0:    word[7:0]   <= bus.rx_data;
                2'd1:    word[15:8]  <= bus.rx_data;
                default: word[23:16] <= bus.rx_data;
              endcase
            end
          end
        end

        WRITE: begin
          bus.imem_ena <= 1'b0;
          bus.imem_wea <= 1'b0;
          word_cnt     <= cnt_next;
          if (17'(cnt_next) == 17'(len)) begin
            state <= DONE;
            start <= 1'b1;
            busy  <= 1'b0;
          end else begin
            byte_idx     <= '0;
            state        <= DATA;
            bus.rx_ready <= 1'b1;
          end
        end

        default: begin
          state        <= IDLE;
          bus.rx_ready <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
